// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, instruction-memory geometry and loader state encoding
package cpu_pkg;

    localparam int INSTR_W    = 12;
    localparam int IMEM_DEPTH = 8;
    localparam logic [INSTR_W-1:0] NOP_WORD = 12'h000;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        PAD,
        DONE
    } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams host words into instruction memory, padding to a full image
module program_loader
    import cpu_pkg::*;
#(
    parameter int                WORD_W   = INSTR_W,
    parameter int                DEPTH    = IMEM_DEPTH,
    parameter logic [WORD_W-1:0] PAD_WORD = NOP_WORD
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic [WORD_W-1:0]          in_data,
    output logic                       in_ready,
    input  logic                       finish,
    output logic                       mem_load,
    output logic [WORD_W-1:0]          mem_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    loader_state_t state;

    assign in_ready = (state == RECV);
    assign busy     = (state == RECV) || (state == PAD);

    // Every session issues exactly DEPTH loads, so image index 0 is always the first word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mem_load <= 1'b0;
            mem_data <= '0;
            count    <= '0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            mem_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RECV;
                        count   <= '0;
                        done    <= 1'b0;
                        overrun <= 1'b0;
                    end
                end
                RECV: begin
                    if (in_valid) begin
                        mem_load <= 1'b1;
                        mem_data <= in_data;
                        count    <= count + 1'b1;
                        if (count == LAST)
                            state <= DONE;
                        else if (finish)
                            state <= PAD;
                    end else if (finish) begin
                        state <= PAD;
                    end
                end
                PAD: begin
                    mem_load <= 1'b1;
                    mem_data <= PAD_WORD;
                    count    <= count + 1'b1;
                    if (count == LAST)
                        state <= DONE;
                end
                DONE: begin
                    // done trails the final load pulse by one cycle.
                    if (start) begin
                        state   <= RECV;
                        count   <= '0;
                        done    <= 1'b0;
                        overrun <= 1'b0;
                    end else begin
                        done <= 1'b1;
                        if (in_valid)
                            overrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - vector table, directed corners and random sessions against a load-stream model
module tb_program_loader;

    localparam int W = 12;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         reset, start, in_valid, finish;
    logic [W-1:0] in_data;
    logic         in_ready, mem_load, busy, done, overrun;
    logic [W-1:0] mem_data;
    logic [3:0]   count;

    program_loader dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .finish(finish), .mem_load(mem_load), .mem_data(mem_data),
        .count(count), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stand-in for the instruction memory: each load pulse writes the next slot.
    logic [W-1:0] mem [D];
    int           widx = 0;
    logic [W-1:0] act_q[$];

    always @(negedge clk) begin
        if (mem_load === 1'b1) begin
            act_q.push_back(mem_data);
            if (widx < D) mem[widx] = mem_data;
            widx++;
        end
    end

    typedef struct {
        logic st, v, fin;
        logic [W-1:0] d;
        logic e_ready, e_busy, e_load;
        logic [W-1:0] e_data;
        logic [3:0] e_cnt;
        logic e_done, e_ovr;
    } vec_t;

    vec_t tbl[15];

    task automatic run_session(input int n, input bit fin_last, input int max_gap, input bit fixed);
        logic [W-1:0] words[D];
        logic [W-1:0] exp_q[$];
        logic [W-1:0] last_data;
        bit mdl_ready, last_hs, hs, got;
        int acc, gap, guard, last_load;
        for (int i = 0; i < D; i++)
            words[i] = fixed ? W'(32'h101 + i) : W'($urandom);
        for (int i = 0; i < D; i++)
            exp_q.push_back(i < n ? words[i] : 12'h000);
        start = 1'b1; in_valid = 1'b0; finish = 1'b0;
        widx = 0; act_q.delete();
        @(posedge clk); #1;
        start = 1'b0;
        mdl_ready = 1'b1; acc = 0; last_hs = 1'b0; last_data = '0; guard = 0;
        gap = $urandom_range(0, max_gap);
        while (mdl_ready && guard < 200) begin
            guard++;
            in_valid = 1'b0; finish = 1'b0;
            if (acc < n) begin
                if (gap > 0) gap--;
                else begin
                    in_valid = 1'b1;
                    in_data  = words[acc];
                    if (fin_last && acc == n - 1) finish = 1'b1;
                end
            end else begin
                finish = 1'b1;
            end
            @(negedge clk);
            chk("recv_in_ready", 32'(in_ready), 32'(1));
            chk("recv_count", 32'(count), 32'(acc));
            if (last_hs) begin
                chk("latency_load", 32'(mem_load), 32'(1));
                chk("latency_data", 32'(mem_data), 32'(last_data));
            end
            hs = in_valid;
            @(posedge clk); #1;
            last_hs = hs; last_data = in_data;
            if (hs) begin
                acc++;
                gap = $urandom_range(0, max_gap);
            end
            if ((hs && acc == D) || finish) mdl_ready = 1'b0;
        end
        if (mdl_ready) chk("recv_timeout", 32'(0), 32'(1));
        in_valid = 1'b0; finish = 1'b0;
        got = 1'b0; last_load = -1;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (k == 0 && last_hs) chk("latency_last_data", 32'(mem_data), 32'(last_data));
            if (mem_load) last_load = k;
            if (done) begin
                got = 1'b1;
                chk("done_after_last_load", 32'(k), 32'(last_load + 1));
            end
        end
        if (!got) chk("done_timeout", 32'(0), 32'(1));
        chk("final_count", 32'(count), 32'(D));
        chk("final_busy", 32'(busy), 32'(0));
        chk("load_total", 32'(act_q.size()), 32'(D));
        for (int i = 0; i < D && i < act_q.size(); i++)
            chk($sformatf("stream[%0d]", i), 32'(act_q[i]), 32'(exp_q[i]));
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          st    v     fin   d        rdy   busy  load  data     cnt   done  ovr
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 12'hA01, 1'b1, 1'b1, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 12'hA02, 1'b1, 1'b1, 1'b1, 12'hA01, 4'd1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 12'hA03, 1'b1, 1'b1, 1'b1, 12'hA02, 4'd2, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 12'hA03, 4'd3, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 12'h000, 4'd4, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 12'h000, 4'd5, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 12'h000, 4'd6, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 12'h000, 4'd7, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h000, 4'd8, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000, 4'd8, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 12'hFFF, 1'b0, 1'b0, 1'b0, 12'h000, 4'd8, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000, 4'd8, 1'b1, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000, 4'd8, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0};

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; finish = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_mem_load", 32'(mem_load), 32'(0));
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_overrun", 32'(overrun), 32'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        // Short program with finish on the last word, then overrun in DONE and restart.
        widx = 0; act_q.delete();
        for (int i = 0; i < 15; i++) begin
            start = tbl[i].st; in_valid = tbl[i].v; finish = tbl[i].fin; in_data = tbl[i].d;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_load", i), 32'(mem_load), 32'(tbl[i].e_load));
            chk($sformatf("tbl%0d_data", i), 32'(mem_data), 32'(tbl[i].e_data));
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].e_done));
            chk($sformatf("tbl%0d_overrun", i), 32'(overrun), 32'(tbl[i].e_ovr));
            @(posedge clk); #1;
        end
        start = 1'b0; in_valid = 1'b0; finish = 1'b0;
        chk("short_loads", 32'(widx), 32'(D));
        for (int i = 0; i < D; i++)
            chk($sformatf("short_mem[%0d]", i), 32'(mem[i]), 32'(i < 3 ? 12'hA01 + i : 0));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;

        // Full image back-to-back.
        run_session(D, 1'b0, 0, 1'b1);
        chk("full_mem0", 32'(mem[0]), 32'h101);
        chk("full_mem7", 32'(mem[7]), 32'h108);

        // Random lengths, gaps and finish placement.
        for (int s = 0; s < 12; s++)
            run_session($urandom_range(0, D), 1'($urandom_range(0, 1)), 3, 1'b0);

        // Reset in the middle of a session.
        start = 1'b1; widx = 0; act_q.delete();
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = W'(32'h201 + i);
            @(posedge clk); #1;
        end
        in_data = 12'h205;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_mem_load", 32'(mem_load), 32'(0));
            chk("abort_ready", 32'(in_ready), 32'(0));
            chk("abort_count", 32'(count), 32'(0));
            chk("abort_busy", 32'(busy), 32'(0));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("abort_loads", 32'(act_q.size()), 32'(4));
        run_session(D, 1'b0, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
